// File: rtl/instr_fetch.sv
// Instruction fetch unit: single outstanding memory request, one-entry hold
// register towards the decoder, redirect with stale-response kill and a
// sticky misalignment halt.
module instr_fetch #(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_rvalid,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] instr_pc,
    output logic             instr_valid,
    input  logic             dec_ready,
    input  logic             branch_en,
    input  logic [WIDTH-1:0] branch_target,
    output logic             misalign_err
);

    typedef enum logic [1:0] {
        BOOT,
        WAIT,
        HOLD,
        HALT
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] instr_q, instr_d;
    logic [WIDTH-1:0] instr_pc_q, instr_pc_d;
    logic             instr_valid_q, instr_valid_d;
    logic             misalign_q, misalign_d;
    logic             kill_q, kill_d;
    logic             target_aligned;

    assign target_aligned = (branch_target[1:0] == 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            misalign_q    <= 1'b0;
            kill_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            misalign_q    <= misalign_d;
            kill_q        <= kill_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        misalign_d    = misalign_q;
        kill_d        = kill_q;

        if (state_q != HALT && branch_en) begin
            if (target_aligned) begin
                pc_d          = branch_target;
                instr_valid_d = 1'b0;
                state_d       = WAIT;
                // A response landing this cycle closes the outstanding request.
                if (state_q == WAIT) begin
                    kill_d = !imem_rvalid;
                end
            end else begin
                misalign_d    = 1'b1;
                instr_valid_d = 1'b0;
                state_d       = HALT;
            end
        end else begin
            case (state_q)
                BOOT: state_d = WAIT;
                WAIT: begin
                    if (imem_rvalid) begin
                        if (kill_q) begin
                            kill_d = 1'b0;
                        end else begin
                            instr_d       = imem_rdata;
                            instr_pc_d    = pc_q;
                            instr_valid_d = 1'b1;
                            state_d       = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (dec_ready) begin
                        pc_d          = pc_q + WIDTH'(4);
                        instr_valid_d = 1'b0;
                        state_d       = WAIT;
                    end
                end
                default: state_d = HALT;
            endcase
        end
    end

    assign imem_req     = (state_q == WAIT);
    assign imem_addr    = pc_q;
    assign instr        = instr_q;
    assign instr_pc     = instr_pc_q;
    assign instr_valid  = instr_valid_q;
    assign misalign_err = misalign_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Randomised bench for instr_fetch: a latency-programmable memory plus a
// stream-level model of which instruction the decoder should see each cycle.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req, u1_imem_req;
    logic [31:0] imem_addr, u1_imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr, u1_instr, instr_pc, u1_instr_pc;
    logic        instr_valid, u1_instr_valid;
    logic        dec_ready = 1'b0;
    logic        branch_en = 1'b0;
    logic [31:0] branch_target = '0;
    logic        misalign_err, u1_misalign_err;

    int n_cmp = 0;
    int n_bad = 0;

    instr_fetch #(.WIDTH(32), .RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr(instr),
        .instr_pc(instr_pc), .instr_valid(instr_valid), .dec_ready(dec_ready),
        .branch_en(branch_en), .branch_target(branch_target), .misalign_err(misalign_err)
    );

    // Shares all inputs with u_dut; only its addresses differ.
    instr_fetch #(.WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst_n(rst_n), .imem_req(u1_imem_req), .imem_addr(u1_imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr(u1_instr),
        .instr_pc(u1_instr_pc), .instr_valid(u1_instr_valid), .dec_ready(dec_ready),
        .branch_en(branch_en), .branch_target(branch_target), .misalign_err(u1_misalign_err)
    );

    always #5 clk = ~clk;

    // Reference model: what the decoder holds, where the next fetch goes.
    bit          m_boot, m_valid, m_halt, m_misalign;
    logic [31:0] m_fetch_pc, m_ipc, m_instr;
    int          m_gen = 0;
    int          m_consumed = 0;

    // Memory: one outstanding request, tagged with the redirect generation.
    bit          mem_const = 1'b0;
    bit          mem_rand = 1'b0;
    int          mem_lat = 0;
    bit          inject_rv = 1'b0;
    bit          mb_busy = 1'b0;
    int          mb_cnt, mb_gen;
    logic [31:0] mb_tag, mb_addr;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return mem_const ? 32'h0000_0013 : ((a * 32'h9E37_79B1) ^ 32'h0000_0013);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_boot = 1'b1;
        m_valid = 1'b0;
        m_halt = 1'b0;
        m_misalign = 1'b0;
        m_fetch_pc = 32'h0;
        m_gen++;
        mb_busy = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        imem_rvalid = 1'b0;
        branch_en = 1'b0;
        dec_ready = 1'b0;
        #1;
        check("rst_valid", {31'b0, instr_valid}, 32'h0);
        check("rst_req", {31'b0, imem_req}, 32'h0);
        check("rst_merr", {31'b0, misalign_err}, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_ipc", instr_pc, 32'h0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_addr_wrap", u1_imem_addr, 32'hFFFF_FFFC);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock cycle: check current outputs, drive inputs, advance model.
    task automatic step(input bit br, input logic [31:0] tgt, input bit rdy);
        bit          rv;
        int          r_gen;
        logic [31:0] r_tag;
        bit          fetching;
        fetching = !m_boot && !m_valid && !m_halt;
        check("valid", {31'b0, instr_valid}, {31'b0, m_valid});
        check("req", {31'b0, imem_req}, {31'b0, fetching});
        check("merr", {31'b0, misalign_err}, {31'b0, m_misalign});
        if (m_valid) begin
            check("ipc", instr_pc, m_ipc);
            check("instr", instr, m_instr);
        end
        if (fetching) check("addr", imem_addr, m_fetch_pc);

        rv = 1'b0;
        r_gen = -1;
        r_tag = '0;
        if (!mb_busy && imem_req) begin
            mb_busy = 1'b1;
            mb_tag = m_fetch_pc;
            mb_addr = imem_addr;
            mb_gen = m_gen;
            mb_cnt = mem_rand ? int'($urandom_range(0, 3)) : mem_lat;
        end
        if (mb_busy && mb_cnt == 0) begin
            rv = 1'b1;
            mb_busy = 1'b0;
            r_gen = mb_gen;
            r_tag = mb_tag;
        end else if (mb_busy) begin
            mb_cnt--;
        end
        if (inject_rv) begin
            rv = 1'b1;
            r_gen = -1;
            inject_rv = 1'b0;
        end
        imem_rvalid = rv;
        imem_rdata = rv ? memf(mb_addr) : $urandom;
        branch_en = br;
        branch_target = tgt;
        dec_ready = rdy;

        if (!m_halt) begin
            if (br && tgt[1:0] == 2'b00) begin
                m_fetch_pc = tgt;
                m_valid = 1'b0;
                m_boot = 1'b0;
                m_gen++;
            end else if (br) begin
                m_halt = 1'b1;
                m_misalign = 1'b1;
                m_valid = 1'b0;
                m_boot = 1'b0;
            end else if (m_boot) begin
                m_boot = 1'b0;
            end else if (!m_valid && rv && r_gen == m_gen) begin
                m_valid = 1'b1;
                m_ipc = r_tag;
                m_instr = memf(r_tag);
            end else if (m_valid && rdy) begin
                m_valid = 1'b0;
                m_fetch_pc = m_fetch_pc + 32'd4;
                m_consumed++;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        bit seen;
        @(negedge clk);

        // Zero-wait streaming, constant NOP memory, plus the wrap instance.
        mem_const = 1'b1;
        mem_lat = 0;
        do_reset();
        step(0, '0, 1);
        step(0, '0, 1);
        step(0, '0, 1);
        check("wrap_addr", u1_imem_addr, 32'h0);
        check("wrap_req", {31'b0, u1_imem_req}, 32'h1);
        for (int i = 0; i < 10; i++) step(0, '0, 1);

        // Decoder stall in HOLD.
        mem_const = 1'b0;
        while (!m_valid) step(0, '0, 0);
        for (int i = 0; i < 5; i++) step(0, '0, 0);
        for (int i = 0; i < 4; i++) step(0, '0, 1);

        // Redirect coinciding with a response and dec_ready.
        if (m_valid) step(0, '0, 1);
        step(1, 32'h0000_0100, 1);
        check("br_addr", imem_addr, 32'h0000_0100);
        for (int i = 0; i < 4; i++) step(0, '0, 1);

        // Slow memory, redirect while the request is in flight.
        mem_lat = 3;
        do_reset();
        step(0, '0, 0);
        step(0, '0, 0);
        step(1, 32'h0000_0040, 0);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (instr_valid) seen = 1'b1;
            else step(0, '0, 0);
        end
        check("kill_seen", {31'b0, seen}, 32'h1);
        check("kill_ipc", instr_pc, 32'h0000_0040);
        step(0, '0, 1);

        // Reset mid-request, then a late strobe during BOOT.
        step(0, '0, 1);
        do_reset();
        inject_rv = 1'b1;
        step(0, '0, 1);
        for (int i = 0; i < 10; i++) step(0, '0, 1);

        // Misaligned redirect halts until reset.
        mem_lat = 1;
        step(1, 32'h0000_0102, 1);
        for (int i = 0; i < 6; i++) step(0, '0, 1);
        step(1, 32'h0000_0200, 1);
        step(0, '0, 1);
        check("halt_merr", {31'b0, misalign_err}, 32'h1);
        do_reset();
        step(0, '0, 1);
        check("restart_addr", imem_addr, 32'h0);

        // Randomised run with variable latency and sparse redirects.
        mem_rand = 1'b1;
        m_consumed = 0;
        for (int i = 0; i < 2000; i++) begin
            bit br;
            br = ($urandom_range(0, 9) == 0);
            step(br, $urandom & 32'h0000_0FFC, $urandom_range(0, 3) != 0);
        end
        check("progress", {31'b0, (m_consumed > 100)}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter WIDTH, default 32: data and address width in bits.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset; SHALL be word-aligned.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 imem_req  output  1  fetch request to instruction memory, held high until the response arrives.
REQ-007 imem_addr  output  WIDTH  byte address of the request; equals pc.
REQ-008 imem_rvalid  input  1  response strobe from memory, one cycle per request.
REQ-009 imem_rdata  input  WIDTH  instruction word, valid with imem_rvalid.
REQ-010 instr  output  WIDTH  fetched instruction to the decoder (the decoder's opcode input).
REQ-011 instr_pc  output  WIDTH  address of instr.
REQ-012 instr_valid  output  1  instr/instr_pc hold a live instruction.
REQ-013 dec_ready  input  1  decoder consumes instr this cycle when high with instr_valid.
REQ-014 branch_en  input  1  redirect request (taken branch/jump).
REQ-015 branch_target  input  WIDTH  redirect address, sampled with branch_en.
REQ-016 misalign_err  output  1  sticky flag: a redirect target was not word-aligned.

Function
REQ-017 The FSM SHALL have states BOOT, WAIT, HOLD, HALT.
REQ-018 BOOT: imem_req=0; next cycle goes to WAIT unconditionally (one dead cycle after reset release).
REQ-019 WAIT: imem_req=1, imem_addr=pc; on imem_rvalid, capture imem_rdata->instr and pc->instr_pc, set instr_valid, go to HOLD.
REQ-020 HOLD: imem_req=0, instr_valid=1, instr/instr_pc stable; on dec_ready, pc<=pc+4 (modulo 2^WIDTH, wraps silently), clear instr_valid, go to WAIT.
REQ-021 Fetch-to-valid latency SHALL be exactly one cycle after the imem_rvalid cycle; max throughput is one instruction per two cycles with a zero-wait memory.
REQ-022 Redirect with branch_target[1:0]==0, in any state other than HALT: pc<=branch_target, instr_valid<=0, state<=WAIT; redirect has priority over imem_rvalid and dec_ready in the same cycle.
REQ-023 A response arriving in the same cycle as a redirect SHALL be discarded; the next request SHALL use branch_target.
REQ-024 A redirect in WAIT whose outstanding request has not yet responded SHALL set a kill flag; the first imem_rvalid after that SHALL be discarded, and WAIT continues with the new pc.
REQ-025 Redirect with branch_target[1:0]!=0: set misalign_err, clear instr_valid, drop imem_req, go to HALT; pc is not updated.
REQ-026 HALT: no requests, instr_valid=0, misalign_err=1; left only by reset.
REQ-027 imem_rvalid while in BOOT, HOLD or HALT SHALL be ignored.
REQ-028 imem_addr SHALL not change while imem_req is high except on a redirect.

Reset
REQ-029 On rst_n low, immediately and independent of clk: state=BOOT, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr=0, instr_pc=0, instr_valid=0, misalign_err=0, kill flag=0.
REQ-030 Reset asserted mid-request SHALL abandon the request; a late imem_rvalid after reset release, before the first WAIT, SHALL be ignored.

Verification
REQ-031 Reset, zero-wait memory returning 32'h0000_0013 for every address, dec_ready=1 -> imem_addr 0,4,8,... ; instr_valid pulses every second cycle with instr_pc 0,4,8.
REQ-032 dec_ready=0 for 5 cycles in HOLD -> instr/instr_pc stable, imem_req=0, pc not advanced; first cycle after dec_ready=1 is WAIT with pc+4.
REQ-033 branch_en with target 32'h0000_0100 in the same cycle as imem_rvalid and dec_ready -> response dropped, instr_valid=0 next cycle, next imem_addr=32'h100.
REQ-034 Memory latency 3 cycles, redirect to 32'h40 one cycle after request issued -> stale response discarded, second response captured with instr_pc=32'h40.
REQ-035 branch_target=32'h0000_0102 -> misalign_err=1, imem_req=0, instr_valid=0 until rst_n low; after reset fetch restarts at RESET_PC.
REQ-036 RESET_PC=32'hFFFF_FFFC, consume one instruction -> next imem_addr=32'h0000_0000.
